multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the KGP_RISC core.
- Owns the 32-bit program counter register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Issues the memory request handshake and generates one-cycle load enables (ir_en, rf_we) for the datapath's D-flip-flop registers.
- Counts retired instructions.

Parameters:
- ADDR_W, 32, width of PC and branch target.
- RESET_PC, 0, PC value after reset.
- PC_INC, 1, PC increment per sequential instruction (word addressing).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset; asynchronous, active-low.
- start  input  1  leave IDLE and begin fetching; ignored in any other state.
- instr_class  input  3  decoded class, sampled in DECODE: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT, 6-7 illegal.
- br_taken  input  1  branch condition, sampled in EXEC.
- br_target  input  ADDR_W  branch/jump target, sampled in EXEC.
- mem_ack  input  1  memory completion; sampled only while mem_req=1.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = store access.
- pc  output  ADDR_W  current program counter.
- ir_en  output  1  instruction register load strobe.
- rf_we  output  1  register file write strobe.
- busy  output  1  1 in any state except IDLE and HALT.
- halted  output  1  1 in HALT.
- err  output  1  sticky; illegal class seen.
- instr_count  output  32  retired-instruction counter.

Behaviour:
- Reset (clr=0, asynchronous, takes effect immediately and mid-instruction):
  - State = IDLE, pc = RESET_PC, instr_count = 0.
  - All other outputs = 0.
- All outputs are registered or decoded from the registered state only; there are no combinational paths from inputs to outputs.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH.
- FETCH:
  - mem_req=1, mem_we=0, held until a rising edge with mem_ack=1.
  - On that edge: ir_en=1 for exactly that one cycle, next state DECODE.
  - Wait cycles are unbounded.
- DECODE: one cycle; latch instr_class. Next state EXEC, except:
  - class 5 -> HALT.
  - class 6/7 -> HALT with err<=1.
- EXEC: one cycle.
  - ALU -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH: pc <= br_taken ? br_target : pc+PC_INC; retire; -> FETCH.
  - JUMP: pc <= br_target; retire; -> FETCH.
- MEM:
  - mem_req=1; mem_we=1 for STORE, 0 for LOAD; held until mem_ack.
  - On the ack edge, LOAD -> WB.
  - On the ack edge, STORE: pc <= pc+PC_INC; retire; -> FETCH.
- WB: rf_we=1 for one cycle; pc <= pc+PC_INC; retire; -> FETCH.
- HALT:
  - halted=1; pc is frozen and retains the address of the HALT instruction.
  - HALT is retired (instr_count+1 on entry); illegal classes are not retired.
  - Exit only via reset.
- Retire: instr_count <= instr_count+1, wrapping from 2^32-1 to 0.
- PC arithmetic: modulo 2^ADDR_W; pc+PC_INC wraps to 0 at the top of the space.
- mem_ack while mem_req=0 is ignored and has no effect.
- mem_req drops in the cycle after the ack edge.
- Minimum latencies with mem_ack=1 immediately, measured from FETCH entry to the next FETCH entry:
  - ALU 4 cycles.
  - LOAD 5 cycles.
  - STORE 4 cycles.
  - BRANCH/JUMP 3 cycles.
- start held high continuously has no effect after IDLE.
- ir_en and rf_we never assert in the same cycle.

Test Plan:
1. Reset, then start with mem_ack tied 1 and class 0 (ALU) three times -> pc 0->1->2->3; each instruction takes 4 cycles; rf_we pulses once per instruction; instr_count=3.
2. LOAD with mem_ack delayed 3 cycles in FETCH and 2 cycles in MEM -> mem_req high 4 and 3 cycles respectively, mem_we=0; ir_en/rf_we single pulses; pc +1 after WB.
3. BRANCH at pc=5 with br_taken=1, br_target=32'h40 -> pc=32'h40. Repeat with br_taken=0 -> pc=6. No rf_we in either case.
4. STORE -> mem_we=1 only in MEM, rf_we never asserts. Then HALT -> halted=1, busy=0, pc frozen, instr_count incremented, further mem_ack/start ignored for 20 cycles.
5. Class 7 -> HALT with err=1, instr_count unchanged. Assert clr=0 mid-FETCH of a later run with mem_req=1 -> mem_req, err, pc (RESET_PC), instr_count clear immediately, without waiting for a clock edge.
6. Preset pc to 2^32-1 via JUMP, then ALU -> pc wraps to 0. Preload instr_count near 2^32-1 (force) and retire -> count wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: owns the PC, walks FETCH/DECODE/EXEC/MEM/WB,
// drives the memory handshake and one-cycle load strobes, counts retirements.
module multicycle_ctrl #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [ADDR_W-1:0]  PC_INC   = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [2:0]        instr_class,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_en,
  output logic              rf_we,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [31:0]       instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_JUMP   = 3'd4;
  localparam logic [2:0] C_HALT   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [2:0]        class_q, class_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       count_q, count_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] pc_seq;

  assign pc_seq = pc_q + PC_INC;

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    pc_d    = pc_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        class_d = instr_class;
        if (instr_class == C_HALT) begin
          state_d = S_HALT;
          count_d = count_q + 32'd1;
        end else if (instr_class > C_HALT) begin
          // Illegal encodings stop the core but are not counted as retired.
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_ALU:           state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            pc_d    = br_taken ? br_target : pc_seq;
            count_d = count_q + 32'd1;
            state_d = S_FETCH;
          end
          C_JUMP: begin
            pc_d    = br_target;
            count_d = count_q + 32'd1;
            state_d = S_FETCH;
          end
          default:         state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (class_q == C_STORE) begin
            pc_d    = pc_seq;
            count_d = count_q + 32'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_seq;
        count_d = count_q + 32'd1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      class_q <= C_ALU;
      pc_q    <= RESET_PC;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Strobes are pure state decodes, so no input reaches an output combinationally.
  assign mem_req     = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_we      = (state_q == S_MEM) && (class_q == C_STORE);
  assign ir_en       = (state_q == S_DECODE);
  assign rf_we       = (state_q == S_WB);
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign err         = err_q;
  assign pc          = pc_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: expands each instruction into its expected phase
// timeline and checks every cycle's outputs, PC and retire count against it.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  instr_class;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_ack;
  logic        mem_req, mem_we, ir_en, rf_we, busy, halted, err;
  logic [31:0] pc, instr_count;

  multicycle_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .instr_class(instr_class),
    .br_taken(br_taken), .br_target(br_target), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .pc(pc), .ir_en(ir_en),
    .rf_we(rf_we), .busy(busy), .halted(halted), .err(err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef enum int {PH_IDLE, PH_FETCH, PH_DEC, PH_EXEC, PH_MEM, PH_WB, PH_HALT} ph_t;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_err;

  // flags = {mem_req, mem_we, ir_en, rf_we, busy, halted, err}
  function automatic logic [6:0] exp_flags(input ph_t ph, input int cls, input logic e);
    logic [6:0] f;
    case (ph)
      PH_IDLE:  f = 7'b0000000;
      PH_FETCH: f = 7'b1000100;
      PH_DEC:   f = 7'b0010100;
      PH_EXEC:  f = 7'b0000100;
      PH_MEM:   f = (cls == 2) ? 7'b1100100 : 7'b1000100;
      PH_WB:    f = 7'b0001100;
      default:  f = 7'b0000010;
    endcase
    f[0] = e;
    return f;
  endfunction

  task automatic check_cycle(input string tag, input ph_t ph, input int cls);
    chk({tag, "/flags"}, 64'({mem_req, mem_we, ir_en, rf_we, busy, halted, err}),
        64'(exp_flags(ph, cls, m_err)));
    chk({tag, "/pc"}, 64'(pc), 64'(m_pc));
    chk({tag, "/cnt"}, 64'(instr_count), 64'(m_cnt));
  endtask

  task automatic noise_inputs();
    instr_class = 3'($urandom_range(0, 7));
    br_taken    = 1'($urandom);
    br_target   = $urandom;
    mem_ack     = 1'($urandom);
    start       = 1'($urandom);
  endtask

  // Called at a negedge with the core in FETCH; returns at the negedge of the next FETCH/HALT.
  task automatic run_instr(input string tag, input int cls, input logic tk,
                           input logic [31:0] tgt, input int fw, input int mw);
    ph_t ph[$];
    int  ack_f, ack_m;
    ack_m = -1;
    for (int i = 0; i <= fw; i++) ph.push_back(PH_FETCH);
    ack_f = fw;
    ph.push_back(PH_DEC);
    if (cls < 5) begin
      ph.push_back(PH_EXEC);
      if (cls == 1 || cls == 2) begin
        ack_m = ph.size() + mw;
        for (int i = 0; i <= mw; i++) ph.push_back(PH_MEM);
      end
      if (cls == 0 || cls == 1) ph.push_back(PH_WB);
    end
    for (int k = 0; k < ph.size(); k++) begin
      check_cycle(tag, ph[k], cls);
      noise_inputs();
      if (ph[k] == PH_DEC) instr_class = 3'(cls);
      if (ph[k] == PH_EXEC) begin
        br_taken  = tk;
        br_target = tgt;
      end
      if (ph[k] == PH_FETCH || ph[k] == PH_MEM) mem_ack = (k == ack_f || k == ack_m);
      @(negedge clk);
    end
    case (cls)
      0, 1, 2: begin m_pc = m_pc + 32'd1; m_cnt = m_cnt + 32'd1; end
      3: begin m_pc = tk ? tgt : m_pc + 32'd1; m_cnt = m_cnt + 32'd1; end
      4: begin m_pc = tgt; m_cnt = m_cnt + 32'd1; end
      5: m_cnt = m_cnt + 32'd1;
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic hold_phase(input string tag, input ph_t ph, input int n);
    for (int k = 0; k < n; k++) begin
      check_cycle(tag, ph, 0);
      noise_inputs();
      if (ph == PH_IDLE) start = 1'b0;
      if (ph == PH_FETCH) mem_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  // Asserts clr away from any clock edge and checks the clear is immediate.
  task automatic do_reset(input string tag);
    clr = 1'b0;
    #1;
    m_pc  = '0;
    m_cnt = '0;
    m_err = 1'b0;
    check_cycle(tag, PH_IDLE, 0);
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b1;
  endtask

  task automatic go();
    check_cycle("idle", PH_IDLE, 0);
    start = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; instr_class = '0; br_taken = 1'b0;
    br_target = '0; mem_ack = 1'b0;
    m_pc = '0; m_cnt = '0; m_err = 1'b0;
    @(negedge clk);
    do_reset("reset");
    hold_phase("idle", PH_IDLE, 3);
    go();

    for (int i = 0; i < 3; i++) run_instr("alu", 0, 1'b0, 32'h0, 0, 0);
    run_instr("load", 1, 1'b0, 32'h0, 3, 2);
    run_instr("alu4", 0, 1'b0, 32'h0, 0, 0);
    run_instr("br_tk", 3, 1'b1, 32'h40, 0, 0);
    run_instr("jmp5", 4, 1'b0, 32'h5, 1, 0);
    run_instr("br_nt", 3, 1'b0, 32'h40, 0, 0);
    run_instr("store", 2, 1'b0, 32'h0, 1, 2);

    for (int i = 0; i < 40; i++)
      run_instr("rand", int'($urandom_range(0, 4)), 1'($urandom), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    run_instr("halt", 5, 1'b0, 32'h0, 2, 0);
    hold_phase("halted", PH_HALT, 20);

    do_reset("reset2");
    go();
    run_instr("alu_b", 0, 1'b0, 32'h0, 0, 0);
    run_instr("illegal", 7, 1'b0, 32'h0, 1, 0);
    hold_phase("err_halt", PH_HALT, 5);

    do_reset("reset3");
    go();
    run_instr("alu_c", 0, 1'b0, 32'h0, 0, 0);
    hold_phase("stall", PH_FETCH, 3);
    do_reset("midfetch");

    go();
    run_instr("jmp_top", 4, 1'b0, 32'hFFFF_FFFF, 0, 0);
    run_instr("pc_wrap", 0, 1'b0, 32'h0, 0, 0);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    m_cnt = 32'hFFFF_FFFF;
    run_instr("cnt_wrap", 0, 1'b0, 32'h0, 0, 0);
    run_instr("after_wrap", 2, 1'b0, 32'h0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
